// File: rtl/snes_mem_responder_if.sv
// Bus bundle between the SNES/MCU request side, the responder and the external
// memory pins. The responder connects through the slave modport; whatever
// drives the requests and models the memory connects through master.
interface snes_mem_responder_if;
  // SNES side
  logic        SNES_RD_START;
  logic        SNES_WR_END;
  logic [23:0] MAP_ADDR;
  logic        ROM_HIT;
  logic        RAM_HIT;
  logic        IS_WRITABLE;
  logic [7:0]  SNES_DATA_IN;
  logic [7:0]  SNES_DATA_OUT;
  // MCU side
  logic        MCU_RRQ;
  logic        MCU_WRQ;
  logic [23:0] MCU_ADDR;
  logic [7:0]  MCU_DOUT;
  logic        MCU_RDY;
  logic [7:0]  MCU_DINR;
  // Memory pins
  logic [23:0] MEM_ADDR;
  logic [7:0]  MEM_DQ_OUT;
  logic [7:0]  MEM_DQ_IN;
  logic        MEM_DQ_OE;
  logic        MEM_OE_N;
  logic        MEM_WE_N;
  logic        MEM_CE0_N;
  logic        MEM_CE1_N;
  logic        BUSY;

  modport slave (
    input  SNES_RD_START, SNES_WR_END, MAP_ADDR, ROM_HIT, RAM_HIT, IS_WRITABLE,
           SNES_DATA_IN, MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, MEM_DQ_IN,
    output SNES_DATA_OUT, MCU_RDY, MCU_DINR, MEM_ADDR, MEM_DQ_OUT, MEM_DQ_OE,
           MEM_OE_N, MEM_WE_N, MEM_CE0_N, MEM_CE1_N, BUSY
  );

  modport master (
    output SNES_RD_START, SNES_WR_END, MAP_ADDR, ROM_HIT, RAM_HIT, IS_WRITABLE,
           SNES_DATA_IN, MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, MEM_DQ_IN,
    input  SNES_DATA_OUT, MCU_RDY, MCU_DINR, MEM_ADDR, MEM_DQ_OUT, MEM_DQ_OE,
           MEM_OE_N, MEM_WE_N, MEM_CE0_N, MEM_CE1_N, BUSY
  );
endinterface

// File: rtl/snes_mem_responder.sv
// Arbitrates SNES and MCU accesses onto a shared async memory (ROM on CE0,
// RAM on CE1). Each side has a one-deep pending slot; SNES wins from IDLE,
// an active access always runs to completion, and every access is followed
// by at least one IDLE cycle with all strobes released.
module snes_mem_responder #(
  parameter int ACCESS_CYCLES = 4  // legal 3..15
) (
  input logic                       CLK,
  input logic                       RST_N,
  snes_mem_responder_if.slave       bus
);

  typedef enum logic [2:0] {IDLE, SRD, SWR, MRD, MWR} state_t;

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_start_snes, w_start_mcu;

  // SNES pending slot
  logic        r_snes_pend, r_snes_wr, r_snes_rom;
  logic [23:0] r_snes_addr;
  logic [7:0]  r_snes_data;
  // MCU pending slot; stays set until its access finishes so repeats drop
  logic        r_mcu_pend, r_mcu_wr;
  logic [23:0] r_mcu_addr;
  logic [7:0]  r_mcu_data;
  // Active access and results
  logic [23:0] r_mem_addr;
  logic [7:0]  r_mem_dout;
  logic        r_sel_rom;
  logic [7:0]  r_snes_dout, r_mcu_dinr;
  logic        r_mcu_rdy;

  logic w_hit, w_snes_rd_ok, w_snes_wr_ok, w_mcu_req, w_last;
  logic w_access, w_is_read, w_is_write, w_is_mcu;

  assign w_hit        = bus.ROM_HIT | bus.RAM_HIT;
  assign w_snes_rd_ok = bus.SNES_RD_START & w_hit;
  assign w_snes_wr_ok = bus.SNES_WR_END & w_hit & bus.IS_WRITABLE;
  assign w_mcu_req    = bus.MCU_RRQ | bus.MCU_WRQ;
  assign w_last       = (r_cnt == LAST);
  assign w_access     = (r_state != IDLE);
  assign w_is_read    = (r_state == SRD) || (r_state == MRD);
  assign w_is_write   = (r_state == SWR) || (r_state == MWR);
  assign w_is_mcu     = (r_state == MRD) || (r_state == MWR);

  // State and access counter register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      // NOTE: every always_ff here uses <= so all registers update from the
      // same pre-edge values; blocking writes would create order-dependent races.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: start a pending access from IDLE (SNES first), else count out
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch forms.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_start_snes = 1'b0;
    w_start_mcu  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (r_snes_pend) begin
          w_start_snes = 1'b1;
          w_state_nxt  = r_snes_wr ? SWR : SRD;
        end else if (r_mcu_pend) begin
          w_start_mcu = 1'b1;
          w_state_nxt = r_mcu_wr ? MWR : MRD;
        end
      end
      default: begin
        if (w_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
    endcase
  end

  // Pending slots, active-access latches and read-data capture
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_snes_pend <= 1'b0;
      r_snes_wr   <= 1'b0;
      r_snes_rom  <= 1'b0;
      r_snes_addr <= '0;
      r_snes_data <= '0;
      r_mcu_pend  <= 1'b0;
      r_mcu_wr    <= 1'b0;
      r_mcu_addr  <= '0;
      r_mcu_data  <= '0;
      r_mem_addr  <= '0;
      r_mem_dout  <= '0;
      r_sel_rom   <= 1'b0;
      r_snes_dout <= '0;
      r_mcu_dinr  <= '0;
      r_mcu_rdy   <= 1'b0;
    end else begin
      // A new strobe overwrites the slot even as its old content starts,
      // so the newer request queues behind the one being launched.
      if (w_snes_rd_ok || w_snes_wr_ok) begin
        r_snes_pend <= 1'b1;
        r_snes_wr   <= w_snes_wr_ok;
        r_snes_rom  <= bus.ROM_HIT;
        r_snes_addr <= bus.MAP_ADDR;
        r_snes_data <= bus.SNES_DATA_IN;
      end else if (w_start_snes) begin
        r_snes_pend <= 1'b0;
      end

      if (w_mcu_req && !r_mcu_pend) begin
        r_mcu_pend <= 1'b1;
        r_mcu_wr   <= bus.MCU_WRQ;
        r_mcu_addr <= bus.MCU_ADDR;
        r_mcu_data <= bus.MCU_DOUT;
      end else if (w_is_mcu && w_last) begin
        r_mcu_pend <= 1'b0;
      end

      if (w_start_snes) begin
        r_mem_addr <= r_snes_addr;
        r_mem_dout <= r_snes_data;
        r_sel_rom  <= r_snes_rom;
      end else if (w_start_mcu) begin
        r_mem_addr <= r_mcu_addr;
        r_mem_dout <= r_mcu_data;
        r_sel_rom  <= (r_mcu_addr[23:22] != 2'b11);
      end

      if (r_state == SRD && w_last) r_snes_dout <= bus.MEM_DQ_IN;
      if (r_state == MRD && w_last) r_mcu_dinr  <= bus.MEM_DQ_IN;
      r_mcu_rdy <= w_is_mcu && w_last;
    end
  end

  // Strobes decode straight from state so reset releases them asynchronously
  assign bus.MEM_CE0_N     = ~(w_access & r_sel_rom);
  assign bus.MEM_CE1_N     = ~(w_access & ~r_sel_rom);
  assign bus.MEM_OE_N      = ~w_is_read;
  assign bus.MEM_DQ_OE     = w_is_write;
  assign bus.MEM_WE_N      = ~(w_is_write && (r_cnt != 4'd0) && !w_last);
  assign bus.MEM_ADDR      = r_mem_addr;
  assign bus.MEM_DQ_OUT    = r_mem_dout;
  assign bus.SNES_DATA_OUT = r_snes_dout;
  assign bus.MCU_DINR      = r_mcu_dinr;
  assign bus.MCU_RDY       = r_mcu_rdy;
  assign bus.BUSY          = w_access;

endmodule

// File: doc/snes_mem_responder.md
SNES_MEM_RESPONDER -- requirements
Module: snes_mem_responder

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 4, memory access length in CLK cycles; legal range 3..15.
REQ-002 SHALL have port CLK, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports SNES_RD_START and SNES_WR_END, input, 1 each: one-cycle pulses from the bus synchronizer.
REQ-005 SHALL have ports MAP_ADDR (input, 24), ROM_HIT, RAM_HIT and IS_WRITABLE (input, 1 each): address-decoder results for the current SNES cycle.
REQ-006 SHALL have ports SNES_DATA_IN (input, 8), write data, and SNES_DATA_OUT (output, 8), read data for the SNES bus.
REQ-007 SHALL have ports MCU_RRQ and MCU_WRQ (input, 1 each), one-cycle request pulses; MCU_ADDR (input, 24); MCU_DOUT (input, 8).
REQ-008 SHALL have ports MCU_RDY (output, 1), one-cycle completion pulse, and MCU_DINR (output, 8), MCU read data.
REQ-009 SHALL have ports MEM_ADDR (output, 24), MEM_DQ_OUT (output, 8), MEM_DQ_IN (input, 8), MEM_DQ_OE (output, 1), and MEM_OE_N, MEM_WE_N, MEM_CE0_N (ROM chip), MEM_CE1_N (RAM chip) (output, 1 each).
REQ-010 SHALL have port BUSY (output, 1), high while any access is in progress.

Function
REQ-011 States: IDLE, SRD, SWR, MRD, MWR; the last four are access states.
REQ-012 On SNES_RD_START with ROM_HIT|RAM_HIT, the block SHALL latch MAP_ADDR and the hit flags and queue an SNES read.
REQ-013 On SNES_WR_END with (ROM_HIT|RAM_HIT)&IS_WRITABLE, it SHALL latch MAP_ADDR, the hit flags and SNES_DATA_IN and queue an SNES write.
REQ-014 An SNES strobe with no hit, or a write with IS_WRITABLE=0, SHALL be ignored: no memory cycle and SNES_DATA_OUT unchanged.
REQ-015 MCU_RRQ/MCU_WRQ SHALL latch MCU_ADDR (and MCU_DOUT for writes) into a one-deep MCU pending slot.
REQ-016 MCU accesses SHALL drive MEM_CE0_N low when MCU_ADDR[23:22]!=2'b11, else MEM_CE1_N.
REQ-017 Priority: from IDLE, a pending SNES access SHALL win over a pending MCU access; an access in progress is never preempted.
REQ-018 A request arriving in the same cycle the FSM is in IDLE SHALL start its access on the next edge; zero-wait pass-through is not required.
REQ-019 Access timing: a counter SHALL run 0..ACCESS_CYCLES-1; MEM_ADDR is stable and the selected CE_N is low for the whole access.
REQ-020 Reads: MEM_OE_N SHALL be low throughout; MEM_DQ_IN SHALL be sampled on the final cycle into SNES_DATA_OUT (SRD) or MCU_DINR (MRD).
REQ-021 Writes: MEM_DQ_OE SHALL be high for the whole access; MEM_WE_N SHALL be low only for counter values 1..ACCESS_CYCLES-2, giving one cycle of setup and one of hold.
REQ-022 MCU_RDY SHALL pulse for exactly one cycle, the cycle after the final access cycle of MRD/MWR; MCU_DINR is valid from that cycle on.
REQ-023 After the final cycle the FSM SHALL return to IDLE for at least one cycle, with all strobes deasserted, before the next access.
REQ-024 A new SNES strobe while an SNES access is already pending (not started) SHALL replace the pending one (newest wins).
REQ-025 A new SNES strobe during an SNES access SHALL be queued and serviced after it.
REQ-026 An MCU request while an MCU access is pending or active SHALL be dropped; MCU_RDY is not pulsed for the dropped request.
REQ-027 Simultaneous SNES and MCU strobes SHALL both be latched; SNES is serviced first.

Reset
REQ-028 While RST_N=0, outputs SHALL be: MEM_OE_N, MEM_WE_N, MEM_CE0_N and MEM_CE1_N =1; MEM_DQ_OE=0; MEM_ADDR=0; MEM_DQ_OUT=0; SNES_DATA_OUT=0; MCU_DINR=0; MCU_RDY=0; BUSY=0.
REQ-029 Reset asserted mid-access SHALL deassert all strobes immediately (asynchronously), clear both pending slots and put the FSM in IDLE; the aborted access produces no MCU_RDY.

Verification
REQ-030 SNES_RD_START, ROM_HIT=1, MAP_ADDR=0x012345, MEM_DQ_IN=0xA5 -> CE0_N and OE_N low for 4 cycles, MEM_ADDR=0x012345, SNES_DATA_OUT=0xA5.
REQ-031 SNES_WR_END, RAM_HIT=1, IS_WRITABLE=1, data 0x3C -> CE1_N low 4 cycles, WE_N low exactly cycles 1-2, MEM_DQ_OUT=0x3C.
REQ-032 SNES_WR_END with ROM_HIT=1, IS_WRITABLE=0 -> no CE/WE activity, BUSY stays 0.
REQ-033 MCU_RRQ and SNES_RD_START in the same cycle -> SNES access first, then MCU access after one idle cycle, MCU_RDY single pulse, MCU_DINR correct.
REQ-034 RST_N low at counter=2 of an MWR -> WE_N/CE_N high in the same cycle without a clock edge; after release, no MCU_RDY and BUSY=0.
REQ-035 Second MCU_RRQ during an active MRD -> dropped; exactly one MCU_RDY observed.
